// File: rtl/ulss_pck_store_if.sv
// ulss_pck_store_if: stream-in / packet-out bus of the packet store.
//   in_sop/in_eop/in_stream : incoming packet words, delimited by sop/eop
//   pck_rd_en_grnt          : one-cycle grant to read one stored packet
//   pck_str_empty/full      : no complete packet stored / word storage full
//   out_valid/sop/eop/stream: outgoing packet words
// master = packet source and scheduler side, slave = the store.
interface ulss_pck_store_if #(
  parameter int DATA_W = 64
);
  logic              in_sop;
  logic              in_eop;
  logic [DATA_W-1:0] in_stream;
  logic              pck_rd_en_grnt;
  logic              pck_str_empty;
  logic              pck_str_full;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [DATA_W-1:0] out_stream;

  modport master (
    output in_sop, in_eop, in_stream, pck_rd_en_grnt,
    input  pck_str_empty, pck_str_full, out_valid, out_sop, out_eop, out_stream
  );

  modport slave (
    input  in_sop, in_eop, in_stream, pck_rd_en_grnt,
    output pck_str_empty, pck_str_full, out_valid, out_sop, out_eop, out_stream
  );
endinterface

// File: rtl/ulss_pck_store.sv
// ulss_pck_store: packet store between a 16-to-4 rate limiter input and its
// scheduler. Whole packets are written, committed on eop and read back one
// packet per grant, with a fixed one-cycle grant-to-first-word latency.
// Ports:
//   rate_limiter_16to4_clk    : clock, rising edge
//   rate_limiter_16to4_rstn   : asynchronous active-low reset
//   rate_limiter_16to4_sw_rst : synchronous active-high soft reset
//   bus                       : ulss_pck_store_if slave modport
//   pck_drop_cnt              : saturating dropped-packet counter, present
//                               only when PCK_STORE_DROP_CNT_EN is defined
//
// Write FSM
//   state   | meaning
//   WR_IDLE | between packets, waiting for in_sop
//   WR_PKT  | storing the words of an open packet
//   WR_DROP | packet overflowed, ignoring words until eop or next sop
// Read FSM
//   state   | meaning
//   RD_IDLE | no packet being output, grant may be accepted
//   RD_PKT  | streaming the words of the granted packet
module ulss_pck_store #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32
) (
  input  logic              rate_limiter_16to4_clk,
  input  logic              rate_limiter_16to4_rstn,
  input  logic              rate_limiter_16to4_sw_rst,
  ulss_pck_store_if.slave   bus
`ifdef PCK_STORE_DROP_CNT_EN
  ,
  output logic [15:0]       pck_drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_e;
  typedef enum logic       {RD_IDLE, RD_PKT}          rd_state_e;

  // Each word keeps its delimiters: {sop, eop, data}
  logic [DATA_W+1:0] mem [DEPTH];

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     start_q, start_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     part_len_q, part_len_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [DATA_W-1:0] out_stream_q, out_stream_d;

  logic              full_now;
  logic              mem_we;
  logic [AW-1:0]     wr_addr;
  logic              rewind;
  logic              commit;
  logic              rd_fire;
  logic              rd_eop;
  logic [DATA_W+1:0] rd_word;

  assign full_now = (wcnt_q == CW'(DEPTH));
  assign rd_word  = mem[rd_ptr_q];

  always_comb begin
    wr_state_d = wr_state_q;
    wr_ptr_d   = wr_ptr_q;
    start_d    = start_q;
    part_len_d = part_len_q;
    mem_we     = 1'b0;
    wr_addr    = wr_ptr_q;
    rewind     = 1'b0;
    commit     = 1'b0;

    unique case (wr_state_q)
      WR_IDLE, WR_DROP: begin
        if (bus.in_sop) begin
          if (full_now) begin
            wr_state_d = WR_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_addr  = wr_ptr_q;
            start_d  = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (bus.in_eop) begin
              commit     = 1'b1;
              part_len_d = '0;
              wr_state_d = WR_IDLE;
            end else begin
              part_len_d = CW'(1);
              wr_state_d = WR_PKT;
            end
          end
        end else if (wr_state_q == WR_DROP && bus.in_eop) begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_PKT: begin
        if (full_now) begin
          // Overflow wins even if a read frees a word this same cycle.
          rewind     = 1'b1;
          wr_ptr_d   = start_q;
          part_len_d = '0;
          wr_state_d = WR_DROP;
        end else if (bus.in_sop) begin
          // Restart: the new packet overwrites the partial from its start.
          rewind   = 1'b1;
          mem_we   = 1'b1;
          wr_addr  = start_q;
          wr_ptr_d = start_q + AW'(1);
          if (bus.in_eop) begin
            commit     = 1'b1;
            part_len_d = '0;
            wr_state_d = WR_IDLE;
          end else begin
            part_len_d = CW'(1);
          end
        end else begin
          mem_we   = 1'b1;
          wr_addr  = wr_ptr_q;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (bus.in_eop) begin
            commit     = 1'b1;
            part_len_d = '0;
            wr_state_d = WR_IDLE;
          end else begin
            part_len_d = part_len_q + CW'(1);
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // Read side: the word is registered onto out_* at the accepting edge,
    // so the state is already RD_IDLE while the eop word is on the bus.
    rd_fire      = (rd_state_q == RD_PKT) ||
                   (rd_state_q == RD_IDLE && bus.pck_rd_en_grnt && !empty_q);
    rd_eop       = rd_fire && rd_word[DATA_W];
    rd_ptr_d     = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_state_d   = rd_fire ? (rd_word[DATA_W] ? RD_IDLE : RD_PKT) : rd_state_q;
    out_valid_d  = rd_fire;
    out_sop_d    = rd_fire && rd_word[DATA_W+1];
    out_eop_d    = rd_eop;
    out_stream_d = rd_fire ? rd_word[DATA_W-1:0] : out_stream_q;

    pkt_cnt_d = pkt_cnt_q + CW'(commit) - CW'(rd_eop);
    wcnt_d    = wcnt_q + CW'(mem_we) - CW'(rd_fire) - (rewind ? part_len_q : '0);
    empty_d   = (pkt_cnt_d == '0);
    full_d    = (wcnt_d == CW'(DEPTH));

    if (rate_limiter_16to4_sw_rst) begin
      wr_state_d   = WR_IDLE;
      rd_state_d   = RD_IDLE;
      wr_ptr_d     = '0;
      start_d      = '0;
      rd_ptr_d     = '0;
      part_len_d   = '0;
      wcnt_d       = '0;
      pkt_cnt_d    = '0;
      empty_d      = 1'b1;
      full_d       = 1'b0;
      out_valid_d  = 1'b0;
      out_sop_d    = 1'b0;
      out_eop_d    = 1'b0;
      out_stream_d = '0;
      mem_we       = 1'b0;
    end
  end

  always_ff @(posedge rate_limiter_16to4_clk) begin
    if (mem_we) mem[wr_addr] <= {bus.in_sop, bus.in_eop, bus.in_stream};
  end

  always_ff @(posedge rate_limiter_16to4_clk or negedge rate_limiter_16to4_rstn) begin
    if (!rate_limiter_16to4_rstn) begin
      wr_state_q   <= WR_IDLE;
      rd_state_q   <= RD_IDLE;
      wr_ptr_q     <= '0;
      start_q      <= '0;
      rd_ptr_q     <= '0;
      part_len_q   <= '0;
      wcnt_q       <= '0;
      pkt_cnt_q    <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_stream_q <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_q      <= start_d;
      rd_ptr_q     <= rd_ptr_d;
      part_len_q   <= part_len_d;
      wcnt_q       <= wcnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_stream_q <= out_stream_d;
    end
  end

  assign bus.pck_str_empty = empty_q;
  assign bus.pck_str_full  = full_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_sop       = out_sop_q;
  assign bus.out_eop       = out_eop_q;
  assign bus.out_stream    = out_stream_q;

`ifdef PCK_STORE_DROP_CNT_EN
  // One event per lost packet: overflow of an open packet, sop arriving
  // while full, or a restart that discards a partial packet.
  logic        drop_evt;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop_evt = (wr_state_q == WR_PKT) ? (full_now || bus.in_sop)
                                           : (bus.in_sop && full_now);

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (rate_limiter_16to4_sw_rst) drop_cnt_d = '0;
  end

  always_ff @(posedge rate_limiter_16to4_clk or negedge rate_limiter_16to4_rstn) begin
    if (!rate_limiter_16to4_rstn) drop_cnt_q <= '0;
    else                          drop_cnt_q <= drop_cnt_d;
  end

  assign pck_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ulss_pck_store.sv
module tb_ulss_pck_store;
  localparam int DW    = 64;
  localparam int DEPTH = 32;

  logic clk;
  logic rstn;
  logic sw_rst;
`ifdef PCK_STORE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  ulss_pck_store_if #(.DATA_W(DW)) bus ();

  ulss_pck_store #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .rate_limiter_16to4_clk    (clk),
    .rate_limiter_16to4_rstn   (rstn),
    .rate_limiter_16to4_sw_rst (sw_rst),
    .bus                       (bus)
`ifdef PCK_STORE_DROP_CNT_EN
    ,
    .pck_drop_cnt              (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: committed packets as a word queue plus a length queue.
  logic [DW-1:0] mq[$];
  int            ml[$];
  int            stored;
  int            drop_exp;
  int            tests;
  int            fails;
  logic [DW-1:0] w0, w1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    check("empty", DW'(bus.pck_str_empty), DW'(ml.size() == 0));
    check("full", DW'(bus.pck_str_full), DW'(stored == DEPTH));
`ifdef PCK_STORE_DROP_CNT_EN
    check("drop_cnt", DW'(drop_cnt), DW'(drop_exp));
`endif
  endtask

  task automatic drive_word(input bit sop, input bit eop, input logic [DW-1:0] d);
    bus.in_sop    = sop;
    bus.in_eop    = eop;
    bus.in_stream = d;
    @(posedge clk); #1;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  // Junk cycles between packets: words without sop must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive_word(1'b0, ($urandom_range(0, 3) == 0), {$urandom, $urandom});
  endtask

  // A packet fits only if all its words fit beside what is already stored.
  task automatic send_pkt(input int len);
    logic [DW-1:0] w[$];
    for (int i = 0; i < len; i++) begin
      w.push_back({$urandom, $urandom});
      drive_word(i == 0, i == len - 1, w[i]);
    end
    if (stored + len <= DEPTH) begin
      foreach (w[i]) mq.push_back(w[i]);
      ml.push_back(len);
      stored += len;
    end else begin
      drop_exp++;
    end
    check_status();
  endtask

  // Read np packets back to back, re-granting in each eop cycle.
  task automatic read_pkts(input int np);
    logic [DW-1:0] exp;
    logic [DW-1:0] last;
    int            len;
    if (np > ml.size()) np = ml.size();
    if (np == 0) return;
    last = '0;
    bus.pck_rd_en_grnt = 1'b1;
    for (int p = 0; p < np; p++) begin
      len = ml.pop_front();
      stored -= len;
      for (int k = 0; k < len; k++) begin
        @(posedge clk); #1;
        bus.pck_rd_en_grnt = (k == len - 1) && (p < np - 1);
        exp = mq.pop_front();
        check("out_valid", DW'(bus.out_valid), DW'(1));
        check("out_sop", DW'(bus.out_sop), DW'(k == 0));
        check("out_eop", DW'(bus.out_eop), DW'(k == len - 1));
        check("out_stream", bus.out_stream, exp);
        last = exp;
      end
    end
    bus.pck_rd_en_grnt = 1'b0;
    @(posedge clk); #1;
    check("out_valid_after", DW'(bus.out_valid), DW'(0));
    check("out_stream_hold", bus.out_stream, last);
    check_status();
  endtask

  task automatic grant_empty_check();
    bus.pck_rd_en_grnt = 1'b1;
    @(posedge clk); #1;
    bus.pck_rd_en_grnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("no_output", DW'(bus.out_valid), DW'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic model_clear();
    mq.delete();
    ml.delete();
    stored   = 0;
    drop_exp = 0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    model_clear();
    rstn   = 1'b0;
    sw_rst = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.in_stream = '0;
    bus.pck_rd_en_grnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", DW'(bus.out_valid), DW'(0));
    check("rst_sop", DW'(bus.out_sop), DW'(0));
    check("rst_eop", DW'(bus.out_eop), DW'(0));
    check("rst_stream", bus.out_stream, '0);
    check_status();
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic 4-word packet, then a single-word packet
    send_pkt(4);
    read_pkts(1);
    send_pkt(1);
    read_pkts(1);

    // Grant with nothing stored, then back-to-back packets
    grant_empty_check();
    send_pkt(3);
    idle(2);
    send_pkt(5);
    send_pkt(1);
    read_pkts(3);

    // Restart after 3 words discards the partial packet
    drive_word(1'b1, 1'b0, {$urandom, $urandom});
    drive_word(1'b0, 1'b0, {$urandom, $urandom});
    drive_word(1'b0, 1'b0, {$urandom, $urandom});
    drop_exp++;
    send_pkt(4);
    read_pkts(1);

    // Overflow: 30 + 4 drops the second; 28 + 4 fills exactly
    send_pkt(30);
    send_pkt(4);
    read_pkts(1);
    send_pkt(28);
    send_pkt(4);
    read_pkts(2);

    // Random traffic with occasional reads
    for (int it = 0; it < 40; it++) begin
      send_pkt($urandom_range(1, 12));
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) read_pkts($urandom_range(1, 3));
    end
    read_pkts(ml.size());

    // Soft reset in the middle of a read
    send_pkt(5);
    bus.pck_rd_en_grnt = 1'b1;
    @(posedge clk); #1;
    bus.pck_rd_en_grnt = 1'b0;
    check("swr_first", bus.out_stream, mq[0]);
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    model_clear();
    check("swr_valid", DW'(bus.out_valid), DW'(0));
    check("swr_stream", bus.out_stream, '0);
    check_status();
    send_pkt(2);
    read_pkts(1);

    // Async reset during the second output word
    send_pkt(4);
    w0 = mq[0];
    w1 = mq[1];
    bus.pck_rd_en_grnt = 1'b1;
    @(posedge clk); #1;
    bus.pck_rd_en_grnt = 1'b0;
    check("ar_w0", bus.out_stream, w0);
    @(posedge clk); #1;
    check("ar_w1", bus.out_stream, w1);
    rstn = 1'b0;
    #1;
    model_clear();
    check("ar_valid", DW'(bus.out_valid), DW'(0));
    check("ar_sop", DW'(bus.out_sop), DW'(0));
    check("ar_eop", DW'(bus.out_eop), DW'(0));
    check("ar_stream", bus.out_stream, '0);
    check_status();
    @(posedge clk); #1;
    rstn = 1'b1;
    grant_empty_check();
    check_status();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ulss_pck_store.md
ULSS_PCK_STORE -- requirements
Module: ulss_pck_store

Interface
REQ-001 Parameter DATA_W, default 64, stream word width.
REQ-002 Parameter DEPTH, default 32, storage in words; power of two, >=4.
REQ-003 rate_limiter_16to4_clk  in  1  single clock; all logic on rising edge.
REQ-004 rate_limiter_16to4_rstn  in  1  reset, asynchronous, active-low.
REQ-005 rate_limiter_16to4_sw_rst  in  1  synchronous soft reset, active-high.
REQ-006 in_sop  in  1  first word of incoming packet.
REQ-007 in_stream  in  DATA_W  incoming word; valid from in_sop cycle through in_eop cycle inclusive.
REQ-008 in_eop  in  1  last word of incoming packet.
REQ-009 pck_rd_en_grnt  in  1  one-cycle grant from the 16-to-4 scheduler to read one packet.
REQ-010 pck_str_empty  out  1  high when no complete packet is stored.
REQ-011 out_valid  out  1  out_stream word valid.
REQ-012 out_sop / out_eop  out  1 each  packet delimiters aligned with out_valid.
REQ-013 out_stream  out  DATA_W  outgoing word.
REQ-014 pck_str_full  out  1  high when stored word count equals DEPTH.

Function
REQ-015 Storage SHALL hold {sop, eop, data} per word; write pointer, read pointer, word count, complete-packet count (pkt_cnt) SHALL be registered.
REQ-016 Write FSM SHALL have states WR_IDLE, WR_PKT, WR_DROP.
REQ-017 WR_IDLE: in_sop writes word, saves start pointer; in_eop same cycle commits single-word packet and stays WR_IDLE, else -> WR_PKT.
REQ-018 WR_PKT: every cycle writes one word; in_eop commits packet (pkt_cnt+1) -> WR_IDLE.
REQ-019 Any write with registered word count == DEPTH SHALL rewind write pointer to saved start, restore word count, and -> WR_DROP; a read in that same cycle SHALL NOT rescue the packet.
REQ-020 WR_DROP SHALL ignore all input words; in_eop -> WR_IDLE; in_sop -> starts new packet as in WR_IDLE.
REQ-021 in_sop while in WR_PKT SHALL discard the partial packet (rewind) and start a new packet at the same cycle's word.
REQ-022 Words without a preceding in_sop in WR_IDLE SHALL be ignored.
REQ-023 pck_str_empty SHALL equal (pkt_cnt == 0), registered; deasserts the cycle after the committing eop write.
REQ-024 Read FSM SHALL have states RD_IDLE, RD_PKT.
REQ-025 Grant accepted only in RD_IDLE with pck_str_empty low; otherwise ignored.
REQ-026 Accepted grant -> RD_PKT; first word on out_* with out_valid and out_sop the cycle after grant (latency 1).
REQ-027 RD_PKT SHALL output one word per cycle, no gaps, until the eop word; on it out_eop=1, pkt_cnt-1, -> RD_IDLE.
REQ-028 Next grant acceptable in the cycle out_eop is high (back-to-back packets allowed).
REQ-029 Simultaneous commit and eop read SHALL leave pkt_cnt unchanged; simultaneous write and read SHALL leave word count unchanged.
REQ-030 Pointers SHALL wrap modulo DEPTH; out_stream SHALL hold last value when out_valid low.

Reset
REQ-031 rstn low SHALL immediately clear pointers, counts, both FSMs to IDLE, out_valid/out_sop/out_eop=0, out_stream=0, pck_str_empty=1, pck_str_full=0.
REQ-032 sw_rst high SHALL apply the same values at next clock edge, overriding all other activity including mid-packet read or write.

Configuration
REQ-033 Macro PCK_STORE_DROP_CNT_EN defined: output pck_drop_cnt (16 bit) counts each packet entering WR_DROP or discarded per REQ-021, saturating at 65535, cleared by both resets.
REQ-034 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-035 Write 4-word packet A0..A3 -> empty low 1 cycle after eop; grant -> A0..A3 on 4 consecutive cycles starting 1 cycle later, sop on A0, eop on A3, empty high after.
REQ-036 Single-word packet (sop&eop same cycle), grant -> one output word with out_sop=out_eop=1.
REQ-037 DEPTH=32: write 30-word packet, then 4-word packet -> second dropped, first intact, full never lost data, pck_drop_cnt=1 (macro on).
REQ-038 Two stored packets, grant again in out_eop cycle -> second packet follows with zero idle cycles; grant while empty -> no output.
REQ-039 in_sop mid-packet after 3 words -> partial discarded, only new packet read back.
REQ-040 Assert rstn low during RD_PKT word 2 -> outputs zero immediately, empty high, subsequent grant ignored.
